branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor for the 5-stage pipeline: direct-mapped BTB with a 2-bit counter per entry.
//  - Replaces static branch resolution in ID. In IF it predicts direction and target for pc_i.
//  - ID/EX returns the resolved outcome through the update port.
//  - MODE selects bimodal (PC index) or gshare (PC index XOR global history).
//  - Saturating counters record branch and mispredict totals.
// PARAMETERS
//  ENTRIES  16  BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
//  TAG_W    8   tag bits, taken from pc[IDX_W+2 +: TAG_W]
//  MODE     0   0 = bimodal, 1 = gshare
//  HIST_W   4   global history bits; 1 <= HIST_W <= IDX_W
//  CNT_W    32  width of the performance counters
// PORTS
//  clk_i             in   1       clock, rising edge
//  rst_i             in   1       asynchronous reset, active-low
//  pc_i              in   32      IF-stage PC being looked up
//  pred_taken_o      out  1       predicted taken (combinational)
//  pred_target_o     out  32      predicted target; valid when pred_taken_o=1
//  pred_hist_o       out  HIST_W  GHR snapshot; pipeline carries it to upd_hist_i
//  upd_valid_i       in   1       resolved branch present this cycle
//  upd_pc_i          in   32      PC of the resolved branch
//  upd_hist_i        in   HIST_W  GHR snapshot taken when this branch was predicted
//  upd_taken_i       in   1       actual direction
//  upd_target_i      in   32      actual taken target
//  upd_pred_taken_i  in   1       direction originally predicted
//  flush_i           in   1       sync invalidate of all entries
//  branch_cnt_o      out  CNT_W   resolved-branch count
//  mispred_cnt_o     out  CNT_W   direction-mispredict count
// BEHAVIOUR
//  - Reset (rst_i=0), async:
//    - all valid bits = 0, all counters = 2'b01 (weakly not-taken), GHR = 0
//    - branch_cnt_o = mispred_cnt_o = 0
//    - outputs then read pred_taken_o = 0, pred_target_o = 0, pred_hist_o = 0
//  - Index:
//    - MODE 0: idx = pc[IDX_W+1:2]
//    - MODE 1: idx = pc[IDX_W+1:2] ^ {0, hist}, hist zero-extended to IDX_W
//    - Lookup uses the current GHR; update uses upd_hist_i.
//  - Lookup, 0 cycles (combinational):
//    - hit = valid[idx] && tag[idx] == pc tag
//    - pred_taken_o = hit && ctr[idx][1]
//    - pred_target_o = hit ? target[idx] : 0
//  - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
//    - Taken increments, not-taken decrements; saturates at 11 and at 00.
//  - Update, registered at the clock edge when upd_valid_i=1:
//    - hit, taken: ctr++ and target <= upd_target_i
//    - hit, not taken: ctr--; target unchanged
//    - miss, taken: allocate (overwrite) -> valid=1, tag, target, ctr = 2'b10
//    - miss, not taken: no change
//    - GHR <= {GHR[HIST_W-2:0], upd_taken_i}; for HIST_W=1, GHR <= upd_taken_i
//    - branch_cnt++; mispred_cnt++ when upd_taken_i != upd_pred_taken_i
//    - Both counters saturate at all-ones and never wrap.
//  - Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents (no bypass).
//  - flush_i=1:
//    - clears all valid bits, resets counters to 01, clears GHR
//    - an update in the same cycle is dropped from the table and GHR
//    - the update still advances the perf counters
//    - perf counters are cleared only by reset
//  - Reset asserted mid-update: reset wins and the update is lost.
//  - No internal stall handling: an IF stall holds pc_i, so the outputs stay stable.
// TESTING
//  - Reset, pc_i=0x40 -> pred_taken_o=0, pred_target_o=0, both counts 0.
//  - MODE0, taken update pc=0x40 tgt=0x80 -> next cycle lookup 0x40: taken=1, target=0x80.
//  - Three not-taken updates to 0x40 after allocation: ctr 10->01->00->00 saturates -> pred_taken_o=0 from the first, tag still hits.
//  - Aliasing, ENTRIES=16: allocate 0x40, then taken update 0x80 (same idx, other tag) -> 0x40 misses, 0x80 hits.
//  - MODE1, HIST_W=4: update pc=0x40 with upd_hist_i=4'b0011 -> entry idx 0x0^0x3=3 set; lookup hits only when GHR=0011.
//  - Counters and flush:
//    - 5 updates, 2 with taken != pred -> 5/2
//    - flush with a simultaneous update -> table empty, counts 6/x
//    - force count to all-ones -> holds

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Indexing is bimodal (MODE=0) or gshare (MODE=1); saturating branch/mispredict counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int MODE    = 0,
    parameter int HIST_W  = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_i,
    output logic              pred_taken_o,
    output logic [31:0]       pred_target_o,
    output logic [HIST_W-1:0] pred_hist_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic [HIST_W-1:0] upd_hist_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [31:0] USED_MASK = (((32'd1 << TAG_W) - 32'd1) << (IDX_W + 2)) |
                                        (((32'd1 << IDX_W) - 32'd1) << 2);

    function automatic logic [IDX_W-1:0] make_idx(input logic [31:0] pc,
                                                  input logic [HIST_W-1:0] hist);
        logic [IDX_W-1:0] h_ext;
        h_ext = '0;
        h_ext[HIST_W-1:0] = hist;
        make_idx = pc[IDX_W+1:2] ^ ((MODE == 1) ? h_ext : '0);
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) ctr_step = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       ctr_step = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]   tag_vec    [ENTRIES];
    logic [31:0]        target_vec [ENTRIES];
    logic [1:0]         ctr_vec    [ENTRIES];

    logic [HIST_W-1:0]  ghr_reg, ghr_next, ghr_shift;
    logic [CNT_W-1:0]   branch_cnt_reg, branch_cnt_next;
    logic [CNT_W-1:0]   mispred_cnt_reg, mispred_cnt_next;

    logic [IDX_W-1:0]   look_idx, upd_idx;
    logic [TAG_W-1:0]   look_tag, upd_tag;
    logic               look_hit, upd_hit;

    // Bits outside the index and tag fields carry no information for the predictor.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i & ~USED_MASK, upd_pc_i & ~USED_MASK};

    // Lookup reads the array as it stands before this cycle's update.
    assign look_idx = make_idx(pc_i, ghr_reg);
    assign look_tag = pc_i[IDX_W+2 +: TAG_W];
    assign look_hit = valid_vec[look_idx] && (tag_vec[look_idx] == look_tag);

    assign pred_taken_o  = look_hit && ctr_vec[look_idx][1];
    assign pred_target_o = look_hit ? target_vec[look_idx] : 32'd0;
    assign pred_hist_o   = ghr_reg;

    assign upd_idx = make_idx(upd_pc_i, upd_hist_i);
    assign upd_tag = upd_pc_i[IDX_W+2 +: TAG_W];
    assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      target_reg;
            logic [1:0]       ctr_reg;
            logic             sel;

            assign sel = upd_valid_i && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= 2'b01;
                end else if (flush_i) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b01;
                end else if (sel) begin
                    if (upd_hit) begin
                        ctr_reg <= ctr_step(ctr_reg, upd_taken_i);
                        if (upd_taken_i) target_reg <= upd_target_i;
                    end else if (upd_taken_i) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target_i;
                        ctr_reg    <= 2'b10;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign ctr_vec[gi]    = ctr_reg;
        end

        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift = upd_taken_i;
        end else begin : g_histn
            assign ghr_shift = {ghr_reg[HIST_W-2:0], upd_taken_i};
        end
    endgenerate

    always_comb begin
        ghr_next         = ghr_reg;
        branch_cnt_next  = branch_cnt_reg;
        mispred_cnt_next = mispred_cnt_reg;
        if (flush_i)          ghr_next = '0;
        else if (upd_valid_i) ghr_next = ghr_shift;
        // Perf counters keep counting through a flush and stick at all-ones.
        if (upd_valid_i) begin
            if (branch_cnt_reg != '1) branch_cnt_next = branch_cnt_reg + 1'b1;
            if ((upd_taken_i != upd_pred_taken_i) && (mispred_cnt_reg != '1))
                mispred_cnt_next = mispred_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ghr_reg         <= '0;
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            ghr_reg         <= ghr_next;
            branch_cnt_reg  <= branch_cnt_next;
            mispred_cnt_reg <= mispred_cnt_next;
        end
    end

    assign branch_cnt_o  = branch_cnt_reg;
    assign mispred_cnt_o = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench: a bimodal and a gshare predictor share one stimulus stream and are checked
// against a table-level reference model.
module tb_branch_predictor;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [3:0]  upd_hist_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic        flush_i;

    logic        p0_taken, p1_taken;
    logic [31:0] p0_target, p1_target;
    logic [3:0]  p0_hist, p1_hist;
    logic [31:0] b0_cnt, m0_cnt;
    logic [3:0]  b1_cnt, m1_cnt;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .MODE(0), .HIST_W(4), .CNT_W(32)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
        .pred_taken_o(p0_taken), .pred_target_o(p0_target), .pred_hist_o(p0_hist),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_hist_i(upd_hist_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i), .flush_i(flush_i),
        .branch_cnt_o(b0_cnt), .mispred_cnt_o(m0_cnt));

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .MODE(1), .HIST_W(4), .CNT_W(4)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
        .pred_taken_o(p1_taken), .pred_target_o(p1_target), .pred_hist_o(p1_hist),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_hist_i(upd_hist_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i), .flush_i(flush_i),
        .branch_cnt_o(b1_cnt), .mispred_cnt_o(m1_cnt));

    // Reference model: one table per predictor, indexed [predictor][entry].
    bit          m_valid [2][16];
    int unsigned m_tag   [2][16];
    int unsigned m_tgt   [2][16];
    int          m_ctr   [2][16];
    int unsigned m_ghr   [2];
    longint      m_br    [2];
    longint      m_mp    [2];
    longint      cnt_max [2] = '{64'hFFFF_FFFF, 64'd15};

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int d, input int unsigned pc, input int unsigned hist);
        m_idx = int'((pc >> 2) & 15) ^ ((d == 1) ? int'(hist & 15) : 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 16; e++) begin
                m_valid[d][e] = 1'b0; m_ctr[d][e] = 1; m_tag[d][e] = 0; m_tgt[d][e] = 0;
            end
            m_ghr[d] = 0; m_br[d] = 0; m_mp[d] = 0;
        end
    endtask

    task automatic model_update();
        int i;
        for (int d = 0; d < 2; d++) begin
            if (upd_valid_i) begin
                if (m_br[d] < cnt_max[d]) m_br[d]++;
                if (upd_taken_i != upd_pred_taken_i && m_mp[d] < cnt_max[d]) m_mp[d]++;
            end
            if (flush_i) begin
                for (int e = 0; e < 16; e++) begin m_valid[d][e] = 1'b0; m_ctr[d][e] = 1; end
                m_ghr[d] = 0;
            end else if (upd_valid_i) begin
                i = m_idx(d, upd_pc_i, upd_hist_i);
                if (m_valid[d][i] && m_tag[d][i] == ((upd_pc_i >> 6) & 255)) begin
                    if (upd_taken_i) begin
                        m_ctr[d][i] = (m_ctr[d][i] < 3) ? m_ctr[d][i] + 1 : 3;
                        m_tgt[d][i] = upd_target_i;
                    end else begin
                        m_ctr[d][i] = (m_ctr[d][i] > 0) ? m_ctr[d][i] - 1 : 0;
                    end
                end else if (upd_taken_i) begin
                    m_valid[d][i] = 1'b1;
                    m_tag[d][i]   = (upd_pc_i >> 6) & 255;
                    m_tgt[d][i]   = upd_target_i;
                    m_ctr[d][i]   = 2;
                end
                m_ghr[d] = ((m_ghr[d] << 1) | 32'(upd_taken_i)) & 15;
            end
        end
    endtask

    task automatic check_lookup(input string tag);
        int i; bit hit;
        logic [63:0] exp_taken, exp_tgt;
        for (int d = 0; d < 2; d++) begin
            i = m_idx(d, pc_i, m_ghr[d]);
            hit = m_valid[d][i] && (m_tag[d][i] == ((pc_i >> 6) & 255));
            exp_taken = 64'(hit && m_ctr[d][i] >= 2);
            exp_tgt   = hit ? 64'(m_tgt[d][i]) : 64'd0;
            check($sformatf("%s_taken%0d pc=%0h", tag, d, pc_i),
                  (d == 0) ? 64'(p0_taken) : 64'(p1_taken), exp_taken);
            check($sformatf("%s_target%0d pc=%0h", tag, d, pc_i),
                  (d == 0) ? 64'(p0_target) : 64'(p1_target), exp_tgt);
            check($sformatf("%s_hist%0d", tag, d),
                  (d == 0) ? 64'(p0_hist) : 64'(p1_hist), 64'(m_ghr[d]));
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_br0"}, 64'(b0_cnt), 64'(m_br[0]));
        check({tag, "_mp0"}, 64'(m0_cnt), 64'(m_mp[0]));
        check({tag, "_br1"}, 64'(b1_cnt), 64'(m_br[1]));
        check({tag, "_mp1"}, 64'(m1_cnt), 64'(m_mp[1]));
    endtask

    // One clock: drive after the falling edge, check lookup before the rising
    // edge, then apply the update to the model and check counters.
    task automatic step(input string tag, input logic [31:0] pc, input logic uv,
                        input logic [31:0] upc, input logic [3:0] uh, input logic ut,
                        input logic [31:0] utg, input logic up, input logic fl);
        pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_hist_i = uh;
        upd_taken_i = ut; upd_target_i = utg; upd_pred_taken_i = up; flush_i = fl;
        #1;
        check_lookup(tag);
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        check_counts(tag);
        $display("step %s pc=%08h upd=%0b upc=%08h hist=%h taken=%0b tgt=%08h pred=%0b flush=%0b",
                 tag, pc, uv, upc, uh, ut, utg, up, fl);
    endtask

    task automatic idle(input string tag, input logic [31:0] pc);
        step(tag, pc, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rpc, rupc;
        logic [3:0]  rh;
        rst_i = 1'b0; pc_i = 32'h40; upd_valid_i = 1'b0; upd_pc_i = '0; upd_hist_i = '0;
        upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0; flush_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_taken", 64'(p0_taken), 64'd0);
        check("reset_target", 64'(p0_target), 64'd0);
        check("reset_br", 64'(b0_cnt), 64'd0);
        check("reset_mp", 64'(m0_cnt), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle("post_reset", 32'h40);

        // Allocation and counter walk on 0x40
        step("alloc", 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        idle("hit_after_alloc", 32'h40);
        check("dir_alloc_taken", 64'(p0_taken), 64'd1);
        check("dir_alloc_target", 64'(p0_target), 64'h80);
        for (int k = 0; k < 3; k++)
            step("nt_walk", 32'h40, 1'b1, 32'h40, 4'(m_ghr[1]), 1'b0, 32'h0, 1'b1, 1'b0);
        idle("sat_low", 32'h40);
        check("dir_sat_taken", 64'(p0_taken), 64'd0);
        check("dir_sat_target", 64'(p0_target), 64'h80);

        // Aliasing: 0x80 maps to the same bimodal entry with another tag
        step("alias", 32'h80, 1'b1, 32'h80, 4'(m_ghr[1]), 1'b1, 32'h200, 1'b0, 1'b0);
        idle("alias_old", 32'h40);
        check("dir_alias_old_miss", 64'(p0_target), 64'd0);
        idle("alias_new", 32'h80);
        check("dir_alias_new_hit", 64'(p0_taken), 64'd1);

        // gshare: entry 3 written through hist 0011; GHR walks to 0011 afterwards
        step("gs_alloc", 32'h100, 1'b1, 32'h40, 4'b0011, 1'b1, 32'h300, 1'b1, 1'b0);
        step("gs_nt0", 32'h40, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("gs_nt1", 32'h40, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("gs_t0", 32'h40, 1'b1, 32'h1000, 4'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        step("gs_t1", 32'h40, 1'b1, 32'h1000, 4'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        idle("gs_lookup", 32'h40);
        check("dir_gs_hist", 64'(p1_hist), 64'b0011);
        check("dir_gs_hit", 64'(p1_target), 64'h300);

        // Flush with a simultaneous update: table empties, counters still advance
        step("flush", 32'h40, 1'b1, 32'h40, 4'd0, 1'b1, 32'h44, 1'b0, 1'b1);
        idle("after_flush", 32'h80);
        check("dir_flush_empty", 64'(p0_target), 64'd0);

        // Random traffic on a small address pool so entries hit and alias
        for (int n = 0; n < 300; n++) begin
            rpc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            rupc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            rh   = ($urandom_range(0, 3) != 0) ? 4'(m_ghr[1]) : 4'($urandom);
            step("rand", rpc, 1'($urandom), rupc, rh, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                 1'($urandom), ($urandom_range(0, 49) == 0));
        end
        check("dir_cnt_sat", 64'(b1_cnt), 64'd15);

        // Reset asserted across an update edge: the update is lost
        pc_i = 32'h40; upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1;
        upd_target_i = 32'h88; flush_i = 1'b0; upd_hist_i = 4'd0;
        rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        upd_valid_i = 1'b0;
        rst_i = 1'b1;
        idle("after_mid_reset", 32'h40);
        check("dir_mid_reset_miss", 64'(p0_taken), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
